// File: rtl/imem_boot_loader.sv
// Boot loader for the RV32I instruction memory.
// Accepts a byte stream (sync 0xA5, 16-bit little-endian word count, 4*N data bytes
// LSB first, XOR checksum), writes each assembled word to consecutive instruction
// memory addresses, and releases the core from reset only after a checksum match.
module imem_boot_loader #(
    parameter int unsigned WORDS  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              core_clr,
    output logic              done,
    output logic              err
);

    localparam logic [7:0] SyncByte = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StCntLo,
        StCntHi,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e state_q, state_d;

    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [15:0]       count_q, count_d;
    // Only the lower three bytes are buffered; the fourth goes straight to im_wdata.
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        csum_q, csum_d;

    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              core_clr_q, core_clr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic [15:0]       count_full;
    logic              last_word;

    assign accept     = rx_valid && rx_ready;
    assign count_full = {rx_data, count_q[7:0]};
    assign last_word  = (32'(word_idx_q) == (32'(count_q) - 32'd1));

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= StIdle;
            byte_idx_q <= '0;
            word_idx_q <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            core_clr_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            word_idx_q <= word_idx_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            core_clr_q <= core_clr_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state and registered-output logic; nothing moves without an accepted byte.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        word_idx_d = word_idx_q;
        count_d    = count_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        core_clr_d = core_clr_q;
        done_d     = done_q;
        err_d      = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept && (rx_data == SyncByte)) begin
                    state_d = StCntLo;
                end
            end
            StCntLo: begin
                if (accept) begin
                    count_d[7:0] = rx_data;
                    state_d      = StCntHi;
                end
            end
            StCntHi: begin
                if (accept) begin
                    count_d = count_full;
                    // Bounding the count here keeps word_idx from ever wrapping.
                    if ((count_full == 16'd0) || (32'(count_full) > WORDS)) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else begin
                        word_idx_d = '0;
                        byte_idx_d = '0;
                        csum_d     = '0;
                        shift_d    = '0;
                        state_d    = StData;
                    end
                end
            end
            StData: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    unique case (byte_idx_q)
                        2'd0: shift_d[7:0]   = rx_data;
                        2'd1: shift_d[15:8]  = rx_data;
                        2'd2: shift_d[23:16] = rx_data;
                        default: begin
                            im_we_d    = 1'b1;
                            im_addr_d  = word_idx_q;
                            im_wdata_d = {rx_data, shift_q};
                        end
                    endcase
                    if (byte_idx_q == 2'd3) begin
                        byte_idx_d = 2'd0;
                        if (last_word) begin
                            state_d = StCsum;
                        end else begin
                            word_idx_d = word_idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            StCsum: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        state_d    = StDone;
                        done_d     = 1'b1;
                        core_clr_d = 1'b0;
                    end else begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StDone;
            end
            StErr: begin
                state_d = StErr;
            end
            default: begin
                state_d = StErr;
                err_d   = 1'b1;
            end
        endcase
    end

    // Handshake output decoded from the current state.
    always_comb begin
        rx_ready = 1'b0;
        unique case (state_q)
            StIdle, StCntLo, StCntHi, StData, StCsum: rx_ready = 1'b1;
            default:                                  rx_ready = 1'b0;
        endcase
    end

    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;
    assign core_clr = core_clr_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream of the instruction memory and program counter in the RV32I core.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into instruction memory at consecutive word addresses, then checks a trailing XOR checksum.
- Holds the core in reset (core_clr) until a load completes successfully.

Parameters:
- WORDS, 256, instruction memory depth in 32-bit words; maximum accepted word count.
- ADDR_W, 8, width of the word address to instruction memory; must satisfy 2**ADDR_W >= WORDS.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  reset, asynchronous, active-high; clears all state.
- rx_valid  input  1  byte on rx_data is valid.
- rx_data  input  8  incoming stream byte.
- rx_ready  output  1  loader can accept a byte this cycle.
- im_we  output  1  one-cycle write strobe to instruction memory.
- im_addr  output  ADDR_W  word address of the write; 0 for the first word.
- im_wdata  output  32  assembled instruction word.
- core_clr  output  1  reset drive to the PC, register file and data memory; active-high.
- done  output  1  sticky; load completed and checksum matched.
- err  output  1  sticky; load aborted (bad count or checksum mismatch).

Behaviour:
- Reset values (asynchronous clr=1):
  - State is IDLE; byte index, word index, count, shift register and checksum are all 0.
  - im_we=0, im_addr=0, im_wdata=0, done=0, err=0, core_clr=1, rx_ready=1.
- A byte is accepted only on a cycle where rx_valid && rx_ready is true. rx_data is sampled on that edge.
- Stream format:
  - 0xA5 sync byte.
  - N[7:0], then N[15:8]: the word count.
  - 4*N data bytes, least-significant byte of each word first.
  - One checksum byte equal to the XOR of all 4*N data bytes.
- States:
  - IDLE: bytes other than 0xA5 are accepted and discarded. 0xA5 goes to CNT_LO.
  - CNT_LO: store the byte as count[7:0]; go to CNT_HI.
  - CNT_HI: store the byte as count[15:8]. If the full count is 0 or greater than WORDS, go to ERR. Otherwise clear the word index and checksum and go to DATA.
  - DATA:
    - Each accepted byte is shifted into word bits [8k+7:8k], where k = byte index 0..3.
    - The checksum XORs in every data byte.
    - On the 4th byte, next cycle: im_we=1 for exactly one cycle, im_addr = word index, im_wdata = the full word.
    - The word index then increments and the byte index wraps to 0.
    - After word N-1 has been written, go to CSUM.
  - CSUM: the accepted byte is compared with the checksum. Match goes to DONE; mismatch goes to ERR.
  - DONE: rx_ready=0, done=1, core_clr=0. Stays here until clr.
  - ERR: rx_ready=0, err=1, core_clr=1. Stays here until clr.
- rx_ready is 1 in IDLE, CNT_LO, CNT_HI, DATA and CSUM.
- im_we, im_addr and im_wdata are registered. im_addr and im_wdata hold their last values when im_we=0.
- core_clr is registered:
  - It deasserts on the same edge that done asserts.
  - It never deasserts while err=1 or before the checksum has matched.
- The byte index and word index never exceed 3 and N-1 respectively. No wrap beyond WORDS is possible because count is bounded in CNT_HI.
- Back-to-back valid bytes (rx_valid held high) must be accepted every cycle with no stall, including across word boundaries.
- clr asserted mid-load:
  - Immediate return to IDLE with all reset values; a partial word is discarded and is not written.
  - Words already written stay in memory; overwriting them is the responsibility of the next load.
- rx_valid=0 in any state: no state change.

Test Plan:
- Reset, then stream A5 01 00 13 05 10 00 16 → one im_we pulse with im_addr=0 and im_wdata=0x00100513 (addi x10,x0,1). Checksum 0x13^0x05^0x10^0x00=0x06 ≠ 0x16 → err=1, core_clr stays 1, done=0.
- Same stream with a final byte of 06 → done=1, core_clr falls on the same edge, rx_ready=0 afterwards, no further im_we.
- Stream 00 FF A5 02 00 followed by 8 data bytes 01..08 and checksum 0x08 → leading 00 and FF discarded. Writes are addr0=0x04030201 and addr1=0x08070605, then done=1.
- Count 0 (A5 00 00) → err=1 after CNT_HI with no im_we. Count WORDS+1 (A5 01 01 for WORDS=256) → err=1.
- rx_valid toggled randomly during a 3-word load → identical im_we/addr/wdata sequence to the continuous case. rx_ready stays 1 until CSUM is accepted.
- clr pulsed after 6 data bytes of a 2-word load → only addr0 written. All outputs return to reset values. A fresh full stream then loads correctly and asserts done.
